qla_episode_ctrl: RTL and testbench
===================================

Name: qla_episode_ctrl

Overview:
Episode sequencer for the Q-learning datapath on the 5x5 gridworld (states 1..25, goal 25, demons 5,7,8,14,17,19,20,22).
- Drives `current_state`, `next_state`, `act`, `step` and `decoder_en` into the QLA core.
- Reads back `Qnext_0..3` to pick actions epsilon-greedily.
- Tracks walls, terminal states and timeouts.
- Runs `NUM_EPISODES` episodes per `start` pulse.

Parameters:
- `START_STATE`, 1: state at which every episode begins (1..25).
- `NUM_EPISODES`, 16'd100: episodes per run (>=1).
- `EPS_THRESH`, 8'd26: explore when `lfsr[7:0] < EPS_THRESH`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (nonzero).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: one-cycle run request; ignored while `busy`.
- `Qnext_0..Qnext_3` in 32 each: signed Q(next_state, a) from the core.
- `current_state` out 5: write address to the core.
- `next_state` out 5: read address to the core.
- `act` out 2: action; 0 up, 1 right, 2 down, 3 left.
- `step` out 4: move index within the episode.
- `decoder_en` out 1: Q-table write enable.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `episode_cnt` out 16: episodes completed in this run.
- `last_outcome` out 2: 0 none, 1 goal, 2 demon, 3 timeout.

Behaviour:
- Reset: state IDLE; `current_state=next_state=START_STATE`; `act=0`, `step=0`, `decoder_en=0`, `busy=0`, `done=0`, `episode_cnt=0`, `last_outcome=0`; lfsr=`LFSR_SEED`. Internal row/col regs are set from `START_STATE`.
- Grid mapping: state = row*5 + col + 1; row 0 is the top row.
- Wall moves (up at row 0, down at row 4, left at col 0, right at col 4) give S'=S.
- FSM: IDLE -> FETCH -> DECIDE -> UPDATE -> ADVANCE -> (FETCH | DONE) -> IDLE. Each move takes 4 cycles.
- IDLE:
  - On `start`, go to FETCH.
  - Set `busy=1`, `episode_cnt=0`, `step=0`, S=`START_STATE`.
- FETCH:
  - `next_state=S`, `current_state=S`.
  - Capture `Qnext_0..3` into internal registers at the end of the cycle.
- DECIDE:
  - `next_state` held at S, so the core's delay regs still hold Q(S,*) going into UPDATE.
  - Advance the LFSR (x^16+x^14+x^13+x^11+1).
  - If `lfsr[7:0] < EPS_THRESH`: `act = lfsr[9:8]`.
  - Else: `act` = signed argmax of the captured Q; ties go to the lowest index.
  - Register `act` and S'.
- UPDATE:
  - `next_state=S'`, `current_state=S`, `step` = current move index.
  - `decoder_en = (state==UPDATE) & ~rst`, so exactly one write per move.
- ADVANCE:
  - Terminal if `step==15` (timeout), else S'==25 (goal), else S' is a demon. This precedence matches the reward generator.
  - Non-terminal: S=S', `step`+1, go to FETCH.
  - Terminal: set `last_outcome`; `episode_cnt`+1; S=`START_STATE`; `step=0`.
    - If the new count == `NUM_EPISODES`: go to DONE.
    - Otherwise: go to FETCH.
- DONE: `done=1` for one cycle, `busy=0`, return to IDLE. `episode_cnt` and `last_outcome` hold until the next `start`.
- `step` never wraps inside an episode; the timeout terminates at 15.
- `rst` mid-run: return to IDLE with reset values at that edge. No write occurs in the reset cycle.
- `start` while `busy`: no effect.

Optional Feature:
- Macro `QLA_CTRL_EPS_DECAY_EN`.
- Defined: an internal epsilon register loads `EPS_THRESH` at `start` and decrements by 1 (saturating at 0) after each completed episode. It replaces `EPS_THRESH` in DECIDE.
- Undefined: `EPS_THRESH` is constant for the whole run.

Test Plan:
- Fixed `EPS_THRESH=0`, `START_STATE=1`, bench holds `Qnext_0..3=0` -> 16 `decoder_en` pulses, each with `act=0`, `current_state=next_state=1`, `step` 0..15. Then `last_outcome=3`, `episode_cnt=1`; for `NUM_EPISODES=1`, `done` pulses once and `busy` falls.
- Greedy signed compare, `EPS_THRESH=0`: `Qnext=(-5,-10,-10,-10)` from state 7 interior -> `act=0`, S'=2. `Qnext=(3,9,9,1)` -> `act=1` (tie to lowest index).
- `EPS_THRESH=0`, `Qnext_1=1`, others 0, `START_STATE=1` -> writes at `current_state` 1,2,3,4 with `next_state` 2,3,4,5. Episode ends after 4 moves with `last_outcome=2`.
- `START_STATE=24`, `Qnext_1` max, `EPS_THRESH=0` -> single write, `current_state=24`, `next_state=25`, `last_outcome=1`, `episode_cnt=1`.
- `rst` asserted during an UPDATE cycle -> `decoder_en=0` in that cycle. Next cycle all outputs at reset values; a following `start` begins at `START_STATE` with `step=0`.
- `EPS_THRESH=8'hFF`, `LFSR_SEED=16'hACE1` -> `act` sequence equals `lfsr[9:8]` of a reference LFSR model. With `QLA_CTRL_EPS_DECAY_EN` defined, after 5 episodes epsilon = 8'hFA.

Source files
------------

// File: rtl/qla_episode_ctrl.sv
// Episode sequencer for the 5x5 gridworld Q-learning core: epsilon-greedy action choice, walls, terminals, timeouts.
// Optional build macro QLA_CTRL_EPS_DECAY_EN: epsilon loads EPS_THRESH at start and decays by 1 per completed episode.
module qla_episode_ctrl #(
  parameter logic [4:0]  START_STATE  = 5'd1,
  parameter logic [15:0] NUM_EPISODES = 16'd100,
  parameter logic [7:0]  EPS_THRESH   = 8'd26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] Qnext_0,
  input  logic signed [31:0] Qnext_1,
  input  logic signed [31:0] Qnext_2,
  input  logic signed [31:0] Qnext_3,
  output logic [4:0]         current_state,
  output logic [4:0]         next_state,
  output logic [1:0]         act,
  output logic [3:0]         step,
  output logic               decoder_en,
  output logic               busy,
  output logic               done,
  output logic [15:0]        episode_cnt,
  output logic [1:0]         last_outcome
);

  localparam logic [2:0] START_ROW = 3'((32'(START_STATE) - 32'd1) / 32'd5);
  localparam logic [2:0] START_COL = 3'((32'(START_STATE) - 32'd1) % 32'd5);
  localparam logic [4:0] GOAL      = 5'd25;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECIDE, S_UPDATE, S_ADVANCE, S_DONE
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic is_demon(input logic [4:0] s);
    case (s)
      5'd5, 5'd7, 5'd8, 5'd14, 5'd17, 5'd19, 5'd20, 5'd22: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] argmax4(input logic signed [31:0] a0, input logic signed [31:0] a1,
                                         input logic signed [31:0] a2, input logic signed [31:0] a3);
    logic [1:0]         idx;
    logic signed [31:0] best;
    idx  = 2'd0;
    best = a0;
    if (a1 > best) begin idx = 2'd1; best = a1; end
    if (a2 > best) begin idx = 2'd2; best = a2; end
    if (a3 > best) begin idx = 2'd3; end
    return idx;
  endfunction

  function automatic logic [4:0] rc_to_state(input logic [2:0] r, input logic [2:0] c);
    return 5'({2'b00, r} * 5'd5 + {2'b00, c} + 5'd1);
  endfunction

  state_t             state_q, state_d;
  logic [4:0]         s_q, s_d;
  logic [2:0]         row_q, row_d, col_q, col_d;
  logic [4:0]         sp_q, sp_d;
  logic [2:0]         sp_row_q, sp_row_d, sp_col_q, sp_col_d;
  logic [1:0]         act_q, act_d;
  logic [3:0]         step_q, step_d;
  logic [15:0]        ep_cnt_q, ep_cnt_d;
  logic [1:0]         outcome_q, outcome_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic signed [31:0] q0_q, q1_q, q2_q, q3_q;
  logic signed [31:0] q0_d, q1_d, q2_d, q3_d;

`ifdef QLA_CTRL_EPS_DECAY_EN
  logic [7:0] eps_q, eps_d;
`endif

  logic [15:0] lfsr_adv;
  logic [7:0]  eps_cur;
  logic [1:0]  act_pick;
  logic [2:0]  mv_row, mv_col;
  logic [15:0] cnt_inc;

  // Decision datapath: explore/exploit choice and wall-clamped move.
  always_comb begin
    lfsr_adv = lfsr_step(lfsr_q);
`ifdef QLA_CTRL_EPS_DECAY_EN
    eps_cur  = eps_q;
`else
    eps_cur  = EPS_THRESH;
`endif
    act_pick = (lfsr_adv[7:0] < eps_cur) ? lfsr_adv[9:8] : argmax4(q0_q, q1_q, q2_q, q3_q);
    mv_row   = row_q;
    mv_col   = col_q;
    case (act_pick)
      2'd0:    if (row_q != 3'd0) mv_row = row_q - 3'd1;
      2'd1:    if (col_q != 3'd4) mv_col = col_q + 3'd1;
      2'd2:    if (row_q != 3'd4) mv_row = row_q + 3'd1;
      default: if (col_q != 3'd0) mv_col = col_q - 3'd1;
    endcase
    cnt_inc = ep_cnt_q + 16'd1;
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    row_d     = row_q;
    col_d     = col_q;
    sp_d      = sp_q;
    sp_row_d  = sp_row_q;
    sp_col_d  = sp_col_q;
    act_d     = act_q;
    step_d    = step_q;
    ep_cnt_d  = ep_cnt_q;
    outcome_d = outcome_q;
    lfsr_d    = lfsr_q;
    q0_d      = q0_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    q3_d      = q3_q;
`ifdef QLA_CTRL_EPS_DECAY_EN
    eps_d     = eps_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          ep_cnt_d  = 16'd0;
          outcome_d = 2'd0;
          step_d    = 4'd0;
          s_d       = START_STATE;
          row_d     = START_ROW;
          col_d     = START_COL;
`ifdef QLA_CTRL_EPS_DECAY_EN
          eps_d     = EPS_THRESH;
`endif
        end
      end
      S_FETCH: begin
        q0_d    = Qnext_0;
        q1_d    = Qnext_1;
        q2_d    = Qnext_2;
        q3_d    = Qnext_3;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        lfsr_d   = lfsr_adv;
        act_d    = act_pick;
        sp_row_d = mv_row;
        sp_col_d = mv_col;
        sp_d     = rc_to_state(mv_row, mv_col);
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // Timeout outranks goal, goal outranks demon, matching the reward generator.
        if (step_q == 4'd15 || sp_q == GOAL || is_demon(sp_q)) begin
          if (step_q == 4'd15)   outcome_d = 2'd3;
          else if (sp_q == GOAL) outcome_d = 2'd1;
          else                   outcome_d = 2'd2;
          ep_cnt_d = cnt_inc;
          s_d      = START_STATE;
          row_d    = START_ROW;
          col_d    = START_COL;
          step_d   = 4'd0;
`ifdef QLA_CTRL_EPS_DECAY_EN
          if (eps_q != 8'd0) eps_d = eps_q - 8'd1;
`endif
          state_d  = (cnt_inc == NUM_EPISODES) ? S_DONE : S_FETCH;
        end else begin
          s_d     = sp_q;
          row_d   = sp_row_q;
          col_d   = sp_col_q;
          step_d  = step_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_q       <= START_STATE;
      row_q     <= START_ROW;
      col_q     <= START_COL;
      sp_q      <= START_STATE;
      sp_row_q  <= START_ROW;
      sp_col_q  <= START_COL;
      act_q     <= 2'd0;
      step_q    <= 4'd0;
      ep_cnt_q  <= 16'd0;
      outcome_q <= 2'd0;
      lfsr_q    <= LFSR_SEED;
`ifdef QLA_CTRL_EPS_DECAY_EN
      eps_q     <= EPS_THRESH;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sp_q      <= sp_d;
      sp_row_q  <= sp_row_d;
      sp_col_q  <= sp_col_d;
      act_q     <= act_d;
      step_q    <= step_d;
      ep_cnt_q  <= ep_cnt_d;
      outcome_q <= outcome_d;
      lfsr_q    <= lfsr_d;
`ifdef QLA_CTRL_EPS_DECAY_EN
      eps_q     <= eps_d;
`endif
    end
  end

  // Captured Q values are pure data and need no reset.
  always_ff @(posedge clk) begin
    q0_q <= q0_d;
    q1_q <= q1_d;
    q2_q <= q2_d;
    q3_q <= q3_d;
  end

  assign current_state = s_q;
  assign next_state    = (state_q == S_UPDATE || state_q == S_ADVANCE) ? sp_q : s_q;
  assign act           = act_q;
  assign step          = step_q;
  assign decoder_en    = (state_q == S_UPDATE) & ~rst;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign episode_cnt   = ep_cnt_q;
  assign last_outcome  = outcome_q;

endmodule

// File: tb/tb_qla_episode_ctrl.sv
// Scoreboard bench for qla_episode_ctrl: directed Q tables on a greedy instance, LFSR reference model on an exploring one.
module tb_qla_episode_ctrl;

  typedef struct packed {
    logic [4:0] cs;
    logic [4:0] ns;
    logic [1:0] act;
    logic [3:0] step;
  } wr_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic [1:0]  outcome;
  } dn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic signed [31:0] qa0, qa1, qa2, qa3;
  logic [4:0]  u1_cs, u1_ns, u2_cs, u2_ns;
  logic [1:0]  u1_act, u2_act, u1_oc, u2_oc;
  logic [3:0]  u1_step, u2_step;
  logic        u1_en, u2_en, u1_busy, u2_busy, u1_done, u2_done;
  logic [15:0] u1_cnt, u2_cnt;

  wr_t exp1[$];
  wr_t exp2[$];
  dn_t dexp1[$];
  dn_t dexp2[$];
  wr_t e1, e2;
  dn_t d1, d2;

  always #5 clk = ~clk;

  qla_episode_ctrl #(.START_STATE(5'd1), .NUM_EPISODES(16'd1), .EPS_THRESH(8'd0), .LFSR_SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .Qnext_0(qa0), .Qnext_1(qa1), .Qnext_2(qa2), .Qnext_3(qa3),
    .current_state(u1_cs), .next_state(u1_ns), .act(u1_act), .step(u1_step),
    .decoder_en(u1_en), .busy(u1_busy), .done(u1_done),
    .episode_cnt(u1_cnt), .last_outcome(u1_oc));

  qla_episode_ctrl #(.START_STATE(5'd1), .NUM_EPISODES(16'd3), .EPS_THRESH(8'hFF), .LFSR_SEED(16'hACE1)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .Qnext_0(32'sd0), .Qnext_1(32'sd0), .Qnext_2(32'sd0), .Qnext_3(32'sd0),
    .current_state(u2_cs), .next_state(u2_ns), .act(u2_act), .step(u2_step),
    .decoder_en(u2_en), .busy(u2_busy), .done(u2_done),
    .episode_cnt(u2_cnt), .last_outcome(u2_oc));

  // Core model for instance 1: Q(next_state, *) from a per-scenario table.
  always_comb begin
    qa0 = 32'sd0; qa1 = 32'sd0; qa2 = 32'sd0; qa3 = 32'sd0;
    case (mode)
      1: qa1 = 32'sd1;
      2: begin
        if (u1_ns == 5'd1) begin
          qa0 = -32'sd1; qa1 = 32'sd5; qa2 = 32'sd5; qa3 = 32'sd0;
        end else if (u1_ns == 5'd2) begin
          qa0 = -32'sd10; qa1 = -32'sd10; qa2 = -32'sd5; qa3 = -32'sd20;
        end
      end
      3: begin
        case (u1_ns)
          5'd1, 5'd6, 5'd13, 5'd18:  qa2 = 32'sd7;
          5'd11, 5'd12, 5'd23, 5'd24: qa1 = 32'sd7;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic wr_t mk(input int cs, input int ns, input int a, input int st);
    wr_t w;
    w.cs = 5'(cs); w.ns = 5'(ns); w.act = 2'(a); w.step = 4'(st);
    return w;
  endfunction

  function automatic dn_t mkd(input int cnt, input int oc);
    dn_t d;
    d.cnt = 16'(cnt); d.outcome = 2'(oc);
    return d;
  endfunction

  // Monitor: every write or done pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (u1_en) begin
        if (exp1.size() == 0) check("u1_unexpected_write", 32'(u1_cs), 32'd0);
        else begin
          e1 = exp1.pop_front();
          check("u1_current_state", 32'(u1_cs), 32'(e1.cs));
          check("u1_next_state", 32'(u1_ns), 32'(e1.ns));
          check("u1_act", 32'(u1_act), 32'(e1.act));
          check("u1_step", 32'(u1_step), 32'(e1.step));
        end
      end
      if (u1_done) begin
        if (dexp1.size() == 0) check("u1_unexpected_done", 32'd1, 32'd0);
        else begin
          d1 = dexp1.pop_front();
          check("u1_episode_cnt", 32'(u1_cnt), 32'(d1.cnt));
          check("u1_last_outcome", 32'(u1_oc), 32'(d1.outcome));
          check("u1_busy_at_done", 32'(u1_busy), 32'd0);
        end
      end
      if (u2_en) begin
        if (exp2.size() == 0) check("u2_unexpected_write", 32'(u2_cs), 32'd0);
        else begin
          e2 = exp2.pop_front();
          check("u2_current_state", 32'(u2_cs), 32'(e2.cs));
          check("u2_next_state", 32'(u2_ns), 32'(e2.ns));
          check("u2_act", 32'(u2_act), 32'(e2.act));
          check("u2_step", 32'(u2_step), 32'(e2.step));
        end
      end
      if (u2_done) begin
        if (dexp2.size() == 0) check("u2_unexpected_done", 32'd1, 32'd0);
        else begin
          d2 = dexp2.pop_front();
          check("u2_episode_cnt", 32'(u2_cnt), 32'(d2.cnt));
          check("u2_last_outcome", 32'(u2_oc), 32'(d2.outcome));
        end
      end
    end
  end

  // Pulse start on instance 1 and wait (bounded) for done; optionally retrigger start mid-run.
  task automatic run1(input string name, input bit mid_start);
    bit seen;
    seen = 1'b0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    if (mid_start) begin
      repeat (5) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      check({name, "_busy_mid_run"}, 32'(u1_busy), 32'd1);
    end
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (u1_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check({name, "_writes_left"}, 32'(exp1.size()), 32'd0);
    check({name, "_done_left"}, 32'(dexp1.size()), 32'd0);
    check({name, "_busy_after"}, 32'(u1_busy), 32'd0);
    check({name, "_done_single"}, 32'(u1_done), 32'd0);
  endtask

  // Reference model for instance 2 (epsilon 0xFF, all Q zero, three episodes).
  task automatic build_model2();
    logic [15:0] l;
    logic [1:0]  a;
    int s, sp, r, c, st, oc;
    l  = 16'hACE1;
    oc = 0;
    for (int ep = 0; ep < 3; ep++) begin
      s = 1; st = 0; oc = 0;
      while (oc == 0) begin
        l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        a = (l[7:0] < 8'hFF) ? l[9:8] : 2'd0;
        r = (s - 1) / 5; c = (s - 1) % 5;
        case (a)
          2'd0: if (r > 0) r--;
          2'd1: if (c < 4) c++;
          2'd2: if (r < 4) r++;
          default: if (c > 0) c--;
        endcase
        sp = r * 5 + c + 1;
        exp2.push_back(mk(s, sp, int'(a), st));
        if (st == 15) oc = 3;
        else if (sp == 25) oc = 1;
        else if (sp inside {5, 7, 8, 14, 17, 19, 20, 22}) oc = 2;
        else begin s = sp; st++; end
      end
    end
    dexp2.push_back(mkd(3, oc));
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_current_state", 32'(u1_cs), 32'd1);
    check("rst_next_state", 32'(u1_ns), 32'd1);
    check("rst_act", 32'(u1_act), 32'd0);
    check("rst_step", 32'(u1_step), 32'd0);
    check("rst_decoder_en", 32'(u1_en), 32'd0);
    check("rst_busy", 32'(u1_busy), 32'd0);
    check("rst_done", 32'(u1_done), 32'd0);
    check("rst_episode_cnt", 32'(u1_cnt), 32'd0);
    check("rst_last_outcome", 32'(u1_oc), 32'd0);

    // All-zero Q: up into the wall every move until the step-15 timeout.
    mode = 0;
    for (int k = 0; k < 16; k++) exp1.push_back(mk(1, 1, 0, k));
    dexp1.push_back(mkd(1, 3));
    run1("timeout", 1'b0);
    check("timeout_cnt_hold", 32'(u1_cnt), 32'd1);
    check("timeout_outcome_hold", 32'(u1_oc), 32'd3);

    // Qnext_1 max: walk right along the top row into demon 5; extra start mid-run is ignored.
    mode = 1;
    exp1.push_back(mk(1, 2, 1, 0));
    exp1.push_back(mk(2, 3, 1, 1));
    exp1.push_back(mk(3, 4, 1, 2));
    exp1.push_back(mk(4, 5, 1, 3));
    dexp1.push_back(mkd(1, 2));
    run1("demon_row", 1'b1);

    // Signed compare with a tie, then an all-negative row leading down into demon 7.
    mode = 2;
    exp1.push_back(mk(1, 2, 1, 0));
    exp1.push_back(mk(2, 7, 2, 1));
    dexp1.push_back(mkd(1, 2));
    run1("signed_tie", 1'b0);

    // Reset during the third UPDATE cycle of a timeout episode.
    mode = 0;
    exp1.push_back(mk(1, 1, 0, 0));
    exp1.push_back(mk(1, 1, 0, 1));
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (u1_en && u1_step == 4'd2) seen = 1'b1;
    end
    check("rst_mid_update_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_decoder_en", 32'(u1_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_current_state", 32'(u1_cs), 32'd1);
    check("rst_mid_next_state", 32'(u1_ns), 32'd1);
    check("rst_mid_act", 32'(u1_act), 32'd0);
    check("rst_mid_step", 32'(u1_step), 32'd0);
    check("rst_mid_busy", 32'(u1_busy), 32'd0);
    check("rst_mid_decoder_en_after", 32'(u1_en), 32'd0);
    check("rst_mid_cnt", 32'(u1_cnt), 32'd0);
    check("rst_mid_outcome", 32'(u1_oc), 32'd0);
    check("rst_mid_writes_left", 32'(exp1.size()), 32'd0);
    exp1.delete();

    // Fresh start after reset: greedy path around the demons to the goal.
    mode = 3;
    exp1.push_back(mk(1, 6, 2, 0));
    exp1.push_back(mk(6, 11, 2, 1));
    exp1.push_back(mk(11, 12, 1, 2));
    exp1.push_back(mk(12, 13, 1, 3));
    exp1.push_back(mk(13, 18, 2, 4));
    exp1.push_back(mk(18, 23, 2, 5));
    exp1.push_back(mk(23, 24, 1, 6));
    exp1.push_back(mk(24, 25, 1, 7));
    dexp1.push_back(mkd(1, 1));
    run1("goal_path", 1'b0);

    // Exploring instance against the LFSR reference model.
    build_model2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (u2_done) seen = 1'b1;
    end
    check("explore_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("explore_writes_left", 32'(exp2.size()), 32'd0);
    check("explore_done_left", 32'(dexp2.size()), 32'd0);
    check("explore_busy_after", 32'(u2_busy), 32'd0);
    check("explore_cnt_hold", 32'(u2_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
